// File: rtl/ixc_gfifo_pkg.sv
// Shared types and defaults for the gfifo scheduler and its arbiters.
package ixc_gfifo_pkg;

  localparam int GF_CBID_W = 20;
  localparam int GF_LEN_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BEAT = 2'd2
  } gf_state_e;

  // Burst descriptor at the default field widths.
  typedef struct packed {
    logic [GF_CBID_W-1:0] cbid;
    logic [GF_LEN_W-1:0]  len;
  } gf_desc_t;

endpackage

// File: rtl/ixc_rr_pick.sv
// Combinational round-robin picker: the first pending port at or after ptr,
// scanning upward and wrapping. ptr is expected to be below NPORT.
module ixc_rr_pick #(
  parameter int NPORT = 4,
  parameter int PTR_W = 4
) (
  input  logic [NPORT-1:0] pend,
  input  logic [PTR_W-1:0] ptr,
  output logic [NPORT-1:0] onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  // Two passes: ports at or above ptr first, then the wrapped lower ports.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int j = 0; j < NPORT; j++) begin
      if (!any && pend[j] && (j >= int'(ptr))) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = PTR_W'(j);
      end
    end
    for (int j = 0; j < NPORT; j++) begin
      if (!any && pend[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/ixc_gfifo_sched.sv
// Central scheduler sharing the GF write interface between NPORT ports.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no burst owned; arbitrate among pending ports
// ST_HDR  | winner granted; present cbid/len header once GF accepts
// ST_BEAT | stream len+1 data beats; ack toggle on the last one
module ixc_gfifo_sched
  import ixc_gfifo_pkg::*;
#(
  parameter int NPORT  = 4,
  parameter int CBID_W = GF_CBID_W,
  parameter int LEN_W  = GF_LEN_W,
  parameter int PTR_W  = 4
) (
  input  logic                    fclk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        preq_tgl,
  input  logic [NPORT*CBID_W-1:0] pcbid,
  input  logic [NPORT*LEN_W-1:0]  plen,
  output logic [NPORT-1:0]        pack_tgl,
  output logic [NPORT-1:0]        pgnt,
  output logic                    GFtsReq,
  output logic [CBID_W-1:0]       GFcbid,
  output logic [LEN_W-1:0]        GFlen,
  output logic                    GFbeat,
  input  logic                    GFfull,
  input  logic                    GFLock,
  output logic                    busy
);

  gf_state_e         state, state_d;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic [LEN_W-1:0]  cnt;
  logic [NPORT-1:0]  pending;
  logic [NPORT-1:0]  pick_oh;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic [CBID_W-1:0] pick_cbid;
  logic [LEN_W-1:0]  pick_len;
  logic              grant_en;
  logic              hdr_acc;
  logic              beat_cnt;
  logic              last_beat;

  // A re-toggle from the granted port during its burst cancels pending until
  // the ack flips pack_tgl, at which point it reappears and is not lost.
  assign pending = preq_tgl ^ pack_tgl;

  ixc_rr_pick #(
    .NPORT (NPORT),
    .PTR_W (PTR_W)
  ) u_pick (
    .pend   (pending),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Select the winning port's descriptor fields from the flat input buses.
  always_comb begin
    pick_cbid = '0;
    pick_len  = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (pick_oh[j]) begin
        pick_cbid = pcbid[j*CBID_W +: CBID_W];
        pick_len  = plen[j*LEN_W +: LEN_W];
      end
    end
  end

  // Next-state decode; GFLock freezes every transition.
  always_comb begin
    state_d   = state;
    grant_en  = 1'b0;
    hdr_acc   = 1'b0;
    beat_cnt  = 1'b0;
    last_beat = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_any && !GFLock) begin
          grant_en = 1'b1;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!GFfull && !GFLock) begin
          hdr_acc = 1'b1;
          state_d = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (!GFfull && !GFLock) begin
          beat_cnt = 1'b1;
          if (cnt == '0) begin
            last_beat = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge fclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Grant, header latch, beat counter, ack toggle and round-robin pointer.
  always_ff @(posedge fclk) begin
    if (rst) begin
      pack_tgl <= '0;
      pgnt     <= '0;
      GFcbid   <= '0;
      GFlen    <= '0;
      win_idx  <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (grant_en) begin
        pgnt    <= pick_oh;
        win_idx <= pick_idx;
        GFcbid  <= pick_cbid;
        GFlen   <= pick_len;
      end
      if (hdr_acc)
        cnt <= GFlen;
      else if (beat_cnt && !last_beat)
        cnt <= cnt - 1'b1;
      if (last_beat) begin
        pack_tgl <= pack_tgl ^ pgnt;
        pgnt     <= '0;
        rr_ptr   <= (win_idx == PTR_W'(NPORT-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  assign GFtsReq = (state == ST_HDR) && !GFfull && !GFLock;
  assign GFbeat  = (state == ST_BEAT) && !GFLock;
  assign busy    = (state != ST_IDLE);

endmodule

// File: doc/ixc_gfifo_sched.md
Name: ixc_gfifo_sched

Overview:
- Central scheduler that shares the single global-FIFO (GF) write interface between NPORT gfifo ports.
- Replaces the distributed tkin/tkout token ring with a round-robin grant plus per-grant burst sequencing.
- Ports post toggle-style requests carrying a cbid and length. The scheduler grants one port at a time and drives the GF request, cbid, len and beat strobes until the burst completes.
- Honours GFfull back-pressure and the global GFLock freeze.

Parameters:
- NPORT, 4, number of requesting ports (2..16).
- CBID_W, 20, callback-id width.
- LEN_W, 12, burst length field width; value L means L+1 beats.
- PTR_W, 4, width of round-robin pointer; must satisfy 2**PTR_W >= NPORT.

Ports:
- fclk  in  1  fast clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- preq_tgl  in  NPORT  per-port request toggle; pending[i] = preq_tgl[i] ^ pack_tgl[i].
- pcbid  in  NPORT*CBID_W  per-port cbid, port i at slice i; stable while pending.
- plen  in  NPORT*LEN_W  per-port burst length, port i at slice i; stable while pending.
- pack_tgl  out  NPORT  per-port acknowledge toggle; flips once when that port's burst completes.
- pgnt  out  NPORT  one-hot; high for every cycle of the owning port's burst.
- GFtsReq  out  1  high for the single cycle in which a burst header (cbid/len) is presented.
- GFcbid  out  CBID_W  header cbid, valid when GFtsReq.
- GFlen  out  LEN_W  header len, valid when GFtsReq.
- GFbeat  out  1  data-beat strobe; the granted port's data is written when GFbeat && !GFfull.
- GFfull  in  1  GF back-pressure.
- GFLock  in  1  freeze: no new grant, no header, no beat advance.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: pack_tgl=0, pgnt=0, GFtsReq=0, GFcbid=0, GFlen=0, GFbeat=0, busy=0, rr_ptr=0, FSM=IDLE, beat counter=0.
- A reset asserted mid-burst aborts the burst. No ack toggle is issued, so the port's request stays pending and is re-served after reset.
- FSM states: IDLE, HDR, BEAT.
- IDLE -> HDR:
  - Condition: any pending bit && !GFLock.
  - Winner: first pending port at or after rr_ptr, scanning upward and wrapping modulo NPORT.
  - Latch winner index, cbid and len. Set pgnt[winner].
  - Grant latency: one cycle from a pending toggle to pgnt.
- HDR:
  - GFtsReq=1 with the latched cbid/len, only when !GFfull && !GFLock.
  - If GFfull or GFLock, hold HDR with GFtsReq=0.
  - On the accepted cycle: load cnt=len, go to BEAT.
- BEAT:
  - GFbeat=1 whenever !GFLock; a beat counts when GFbeat && !GFfull.
  - Each counted beat with cnt!=0 decrements cnt.
  - The counted beat with cnt==0 is the last beat. On it: toggle pack_tgl[winner], clear pgnt, set rr_ptr=winner+1 (wrapping at NPORT), go to IDLE.
  - len=0 gives exactly 1 beat. len=2**LEN_W-1 gives 4096 beats; the counter must not wrap.
- GFLock:
  - Asserted in any state, it freezes state, counter and grant.
  - GFtsReq and GFbeat are forced low while it is high.
  - Deassertion resumes on the next cycle with no lost or duplicated beat.
- Requests:
  - A new toggle on the currently granted port during its burst is not lost. It remains pending after the ack and is eligible for the next arbitration.
  - A port toggling twice before service is a protocol error; the bench asserts this never happens.
- Fairness: each port waits at most NPORT-1 bursts.
- Back-to-back bursts: IDLE is occupied for exactly one cycle between bursts. Minimum burst cost is 3 cycles (IDLE, HDR, BEAT).
- Outputs are registered except GFbeat and GFtsReq, which are the registered state gated combinationally by !GFLock.

Decomposition:
- Package ixc_gfifo_pkg:
  - FSM state enum (IDLE/HDR/BEAT).
  - Constants for default CBID_W/LEN_W.
  - A descriptor struct {cbid, len}.
- Sub-module ixc_rr_pick:
  - Combinational round-robin picker: pending vector + rr_ptr -> one-hot winner + index + any.
  - Reusable by other gfifo arbiters.

Test Plan:
- Single request: port 2 toggles, plen=3, GFfull=0 -> pgnt=4'b0100 next cycle, GFtsReq one cycle with GFlen=3, exactly 4 GFbeat cycles, pack_tgl[2] flips, busy low after.
- All four ports toggle the same cycle, rr_ptr=0, all len=0 -> grants in order 0,1,2,3, each burst 3 cycles, total 12 cycles; ack toggles in that order.
- Back-pressure: port 1 len=2, GFfull high for 5 cycles at the second beat -> counted beats still 3, no extra ack, completion delayed by 5 cycles.
- Lock: GFLock high 4 cycles during HDR -> GFtsReq low throughout the lock, then one header pulse; during BEAT, the beat count is unchanged by the lock.
- Reset mid-burst: rst at beat 2 of a len=5 burst on port 3 -> all outputs return to reset values; pending[3] is still set and the port is re-granted with a full header and 6 beats.
- Max length: plen=12'hFFF -> exactly 4096 counted beats, single ack, no counter wrap.
